// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the 4x4 keypad scanner.
// master = scanner (drives columns and the key strobe), slave = keypad/lock side.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_validn;
  logic [2:0] dbg_state;

  // key_validn is an active-low strobe with no back-pressure: key_code is
  // stable one cycle before the fall and until the next accepted key.
  modport master (input row_n, output col_n, output key_code, output key_validn, output dbg_state);
  modport slave  (output row_n, input col_n, input key_code, input key_validn, input dbg_state);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, per-frame closure classification,
// frame-level debounce and a single active-low strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 5,
  parameter int STROBE_CYCLES   = 8
) (
  input logic              MAX10_CLK1_50,
  input logic              reset,
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int SW = $clog2(STROBE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_SETUP    = 3'd2,
    S_STROBE   = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  logic [3:0]    rows_s1_q, rows_s2_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    col_q;
  logic [3:0]    col_n_q;
  logic [1:0]    hits_q;
  logic [3:0]    code_acc_q;

  state_t        state_q;
  logic [3:0]    cand_q;
  logic [FW-1:0] cnt_q;
  logic [SW-1:0] strb_q;
  logic [3:0]    key_code_q;
  logic          validn_q;

  logic          dwell_last, frame_end;
  logic [1:0]    col_nxt;
  logic [2:0]    col_hits, hits_sum;
  logic [1:0]    col_row;
  logic [1:0]    hits_d;
  logic [3:0]    code_d;
  logic [FW-1:0] cnt_inc;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hF;  4'hD: k = 4'h0;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign dwell_last = (dwell_q == DW'(SCAN_DIV - 1));
  assign frame_end  = dwell_last && (col_q == 2'd3);
  assign col_nxt    = col_q + 2'd1;
  assign cnt_inc    = (cnt_q == FW'(DEBOUNCE_FRAMES)) ? cnt_q : cnt_q + FW'(1);

  // Closures seen so far this frame, including the column sampled this cycle;
  // the count saturates at 2 since only none/one/many matters.
  always_comb begin
    col_hits = 3'd0;
    col_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!rows_s2_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    if (!dwell_last) begin
      col_hits = 3'd0;
    end
    hits_sum = {1'b0, hits_q} + ((col_hits > 3'd2) ? 3'd2 : col_hits);
    hits_d   = (hits_sum > 3'd2) ? 2'd2 : hits_sum[1:0];
    code_d   = (hits_q == 2'd0 && col_hits == 3'd1) ? key_map(col_row, col_q) : code_acc_q;
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      rows_s1_q  <= 4'hF;
      rows_s2_q  <= 4'hF;
      dwell_q    <= '0;
      col_q      <= 2'd0;
      col_n_q    <= 4'b1110;
      hits_q     <= 2'd0;
      code_acc_q <= 4'h0;
    end else begin
      rows_s1_q <= kp.row_n;
      rows_s2_q <= rows_s1_q;
      if (dwell_last) begin
        dwell_q    <= '0;
        col_q      <= col_nxt;
        col_n_q    <= ~(4'b0001 << col_nxt);
        hits_q     <= frame_end ? 2'd0 : hits_d;
        code_acc_q <= frame_end ? 4'h0 : code_d;
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end
    end
  end

  // Frame results landing while in SETUP or STROBE are deliberately dropped.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cand_q     <= 4'h0;
      cnt_q      <= '0;
      strb_q     <= '0;
      key_code_q <= 4'h0;
      validn_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_end && hits_d == 2'd1) begin
            cand_q <= code_d;
            if (DEBOUNCE_FRAMES <= 1) begin
              state_q <= S_SETUP;
              cnt_q   <= '0;
            end else begin
              state_q <= S_DEBOUNCE;
              cnt_q   <= FW'(1);
            end
          end
        end
        S_DEBOUNCE: begin
          if (frame_end) begin
            if (hits_d == 2'd1 && code_d == cand_q) begin
              if (cnt_inc == FW'(DEBOUNCE_FRAMES)) begin
                state_q <= S_SETUP;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else if (hits_d == 2'd1) begin
              cand_q <= code_d;
              cnt_q  <= FW'(1);
            end else begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end
          end
        end
        S_SETUP: begin
          key_code_q <= cand_q;
          strb_q     <= '0;
          state_q    <= S_STROBE;
        end
        S_STROBE: begin
          if (strb_q == SW'(STROBE_CYCLES)) begin
            validn_q <= 1'b1;
            strb_q   <= '0;
            cnt_q    <= '0;
            state_q  <= S_RELEASE;
          end else begin
            validn_q <= 1'b0;
            strb_q   <= strb_q + SW'(1);
          end
        end
        S_RELEASE: begin
          if (frame_end) begin
            if (hits_d == 2'd0) begin
              if (cnt_inc == FW'(DEBOUNCE_FRAMES)) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q <= '0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign kp.col_n      = col_n_q;
  assign kp.key_code   = key_code_q;
  assign kp.key_validn = validn_q;
  assign kp.dbg_state  = state_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix keypad model and a strobe monitor.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keys;
  logic [3:0]  row_model;
  int          checks = 0;
  int          failures = 0;

  int          strobes = 0;
  int          low_run = 0;
  int          last_low_len = 0;
  logic [3:0]  code_at_fall = 4'h0;
  logic [3:0]  code_before_fall = 4'h0;
  logic        prev_vn = 1'b1;
  logic [3:0]  prev_code = 4'h0;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_FRAMES(2),
    .STROBE_CYCLES(8)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset(reset),
    .kp(kp)
  );

  always #5 clk = ~clk;

  // Key (r,c) is keys[r*4+c]; a closed key pulls its row low while its column is driven.
  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_model[r] = ~|(keys[r*4 +: 4] & ~kp.col_n);
    end
  end
  assign kp.row_n = row_model;

  always @(negedge clk) begin
    if (prev_vn && !kp.key_validn) begin
      strobes          = strobes + 1;
      code_at_fall     = kp.key_code;
      code_before_fall = prev_code;
      low_run          = 1;
    end else if (!kp.key_validn) begin
      low_run = low_run + 1;
    end
    if (!prev_vn && kp.key_validn) last_low_len = low_run;
    prev_vn   = kp.key_validn;
    prev_code = kp.key_code;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that starts a frame (column 0 driven again).
  task automatic align();
    int n;
    n = 0;
    while (kp.col_n != 4'b0111 && n < 40) begin step(1); n++; end
    while (kp.col_n != 4'b1110 && n < 40) begin step(1); n++; end
    check("align_timeout", 32'(n < 40), 32'd1);
  endtask

  initial begin
    keys  = 16'h0;
    reset = 1'b1;
    #2;
    // 1: reset state and column stepping
    check("rst_col_n", kp.col_n, 4'b1110);
    check("rst_key_code", kp.key_code, 4'h0);
    check("rst_validn", kp.key_validn, 1'b1);
    check("rst_state", kp.dbg_state, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    step(3);
    check("col0_hold", kp.col_n, 4'b1110);
    step(1);
    check("col1", kp.col_n, 4'b1101);
    step(4);
    check("col2", kp.col_n, 4'b1011);
    step(4);
    check("col3", kp.col_n, 4'b0111);
    step(4);
    check("col0_wrap", kp.col_n, 4'b1110);

    // 2: hold '5' for 10 frames
    align();
    keys = 16'h1 << 5;
    step(33);
    check("k5_code_before_fall", kp.key_code, 4'h5);
    check("k5_validn_high", kp.key_validn, 1'b1);
    check("k5_state_strobe", kp.dbg_state, 3'd3);
    step(1);
    check("k5_validn_fall", kp.key_validn, 1'b0);
    step(7);
    check("k5_validn_last_low", kp.key_validn, 1'b0);
    step(1);
    check("k5_validn_rise", kp.key_validn, 1'b1);
    step(160 - 42);
    check("k5_strobe_count", strobes, 1);
    check("k5_code_at_fall", code_at_fall, 4'h5);
    check("k5_code_prev_cycle", code_before_fall, 4'h5);
    check("k5_low_len", last_low_len, 8);
    keys = 16'h0;
    step(64);

    // 3: '9' pressed one frame, released one frame, five times
    align();
    for (int i = 0; i < 5; i++) begin
      keys = 16'h1 << 10;
      step(16);
      keys = 16'h0;
      step(16);
    end
    check("k9_bounce_no_strobe", strobes, 1);
    check("k9_code_held", kp.key_code, 4'h5);

    // 4: '1' and '2' together, then '1' alone
    align();
    keys = 16'h3;
    step(64);
    check("multi_no_strobe", strobes, 1);
    keys = 16'h1;
    step(33);
    check("k1_code", kp.key_code, 4'h1);
    step(1);
    check("k1_validn_fall", kp.key_validn, 1'b0);
    step(30);
    check("k1_strobe_count", strobes, 2);
    keys = 16'h0;
    step(64);

    // 5: '*', '#', then '*' after only one empty frame
    align();
    keys = 16'h1 << 12;
    step(64);
    check("star_count", strobes, 3);
    check("star_code", code_at_fall, 4'hF);
    keys = 16'h0;
    step(64);
    keys = 16'h1 << 14;
    step(64);
    check("hash_count", strobes, 4);
    check("hash_code", code_at_fall, 4'hE);
    keys = 16'h0;
    step(16);
    keys = 16'h1 << 12;
    step(96);
    check("star_short_release_count", strobes, 4);
    check("star_short_release_code", kp.key_code, 4'hE);
    keys = 16'h0;
    step(64);
    keys = 16'h1 << 12;
    step(64);
    check("star_again_count", strobes, 5);
    check("star_again_code", code_at_fall, 4'hF);
    keys = 16'h0;
    step(64);

    // 6: reset on the third low cycle of a strobe, key '7' kept held
    align();
    keys = 16'h1 << 8;
    step(34);
    check("k7_validn_fall", kp.key_validn, 1'b0);
    step(2);
    check("k7_third_low", kp.key_validn, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_validn", kp.key_validn, 1'b1);
    check("midrst_key_code", kp.key_code, 4'h0);
    check("midrst_col_n", kp.col_n, 4'b1110);
    check("midrst_state", kp.dbg_state, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    step(96);
    check("k7_restrobe_count", strobes, 7);
    check("k7_restrobe_code", code_at_fall, 4'h7);
    check("k7_restrobe_low_len", last_low_len, 8);
    check("k7_key_code", kp.key_code, 4'h7);
    keys = 16'h0;
    step(64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, debounces it, and produces the `key_code` / `key_validn` pair consumed by the combination-lock controller. The block drives the column lines, samples the row lines, and accepts exactly one key per press. It sits directly upstream of the lock controller. Its strobe is held low long enough for that controller's two-flop synchronizer and its sample-on-second-low-cycle logic.

## Interface

**Parameters**
- `SCAN_DIV`, default 50000: clock cycles each column is driven. Must be ≥ 4.
- `DEBOUNCE_FRAMES`, default 5: consecutive identical full-scan frames needed to accept a press or a release.
- `STROBE_CYCLES`, default 8: cycles `key_validn` is held low. Must be ≥ 4.

**Ports**
- `MAX10_CLK1_50`, in, 1: the only clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `row_n`, in, 4: keypad rows, pulled up externally; low means a key is closed on the driven column.
- `col_n`, out, 4: column drive, active-low one-hot.
- `key_code`, out, 4: code of the last accepted key.
- `key_validn`, out, 1: active-low strobe marking a new key.

## Operation

- `row_n` passes through a 2-flop synchronizer before use.
- **Column scan**
  - The scan runs continuously in every FSM state, in column order 0→1→2→3→0.
  - Each column is driven for `SCAN_DIV` cycles.
  - Synchronized rows are sampled on the last cycle of each dwell.
  - Four dwells make one frame. A frame-end pulse fires on the last cycle of column 3.
- **Frame result**, evaluated at frame end:
  - NONE: no closure seen.
  - SINGLE(code): exactly one closure seen in the whole frame.
  - MULTI: two or more closures.
- **Key map** (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: F 0 E D
  - `*` maps to F (clear) and `#` maps to E (enter).
- **FSM.** All transitions happen only on frame-end pulses, except SETUP and STROBE.
  - IDLE
    - SINGLE(k): go to DEBOUNCE with cand=k, cnt=1.
    - Anything else: stay.
  - DEBOUNCE
    - SINGLE(cand): cnt+1.
    - SINGLE(other k): cand=k, cnt=1.
    - NONE or MULTI: go to IDLE, cnt=0.
    - When cnt reaches `DEBOUNCE_FRAMES`, go to SETUP on that same frame-end edge.
  - SETUP, one cycle: `key_code` loads cand; go to STROBE.
  - STROBE: `key_validn`=0 for exactly `STROBE_CYCLES` cycles, then `key_validn`=1 and go to RELEASE.
  - RELEASE
    - NONE: cnt+1.
    - SINGLE or MULTI: cnt=0.
    - When cnt reaches `DEBOUNCE_FRAMES`, go to IDLE.
- A held key produces exactly one strobe. Repeating the same key requires a full release first.
- `key_code` holds its value between strobes. It changes only in SETUP.
- **Widths**
  - Dwell counter: `$clog2(SCAN_DIV)` bits.
  - Frame counter: `$clog2(DEBOUNCE_FRAMES+1)` bits.
  - Strobe counter: `$clog2(STROBE_CYCLES+1)` bits.
  - All counters saturate or clear; none wraps.

## Timing

- **Reset values** (asynchronous, immediate):
  - `col_n`=4'b1110
  - `key_code`=4'h0
  - `key_validn`=1
  - FSM in IDLE, all counters 0, synchronizer flops 1.
- Reset asserted mid-STROBE: `key_validn` returns to 1 asynchronously. No partial strobe resumes after release of reset.
- **Press latency:** accept happens at the end of the `DEBOUNCE_FRAMES`-th consecutive SINGLE frame.
  - The accepting frame-end edge is also the edge that enters SETUP.
  - Edge +1 (end of the SETUP cycle): `key_code` updated.
  - Edge +2: `key_validn` falls.
  - `key_validn` rises after `STROBE_CYCLES` more edges.
- `key_code` is stable ≥1 cycle before `key_validn` falls and stays stable until the next SETUP, well after the rising edge.
- `col_n` changes only at dwell boundaries. Exactly one bit is low at all times after reset.
- Frame-end coinciding with SETUP or STROBE: the frame result is ignored. RELEASE counting starts with the first frame-end after STROBE ends.

## Test plan

Test parameters: `SCAN_DIV`=4, `DEBOUNCE_FRAMES`=2, `STROBE_CYCLES`=8. A keypad model pulls `row_n[r]` low when `col_n[c]`=0 and key (r,c) is pressed.

1. Assert reset with no keys pressed, then deassert → `col_n`=1110, `key_code`=0, `key_validn`=1. `col_n` steps 1101 / 1011 / 0111 every 4 cycles.
2. Hold key '5' (r1,c1) for 10 frames → exactly one strobe. `key_code`=5 one cycle before `key_validn` falls; `key_validn` is low for exactly 8 cycles.
3. Press '9' for 1 frame, release for 1 frame, repeated 5 times → `key_validn` never falls.
4. Hold '1' and '2' together for 4 frames, then release '2' and keep '1' → no strobe while both are held. Then one strobe with `key_code`=1 after 2 SINGLE frames.
5. Press `*`, then release, then press `#` → `key_code`=F, then `key_code`=E. Pressing `*` again after only 1 empty frame, held → no second strobe until 2 consecutive NONE frames have been seen.
6. Assert reset on the 3rd low cycle of a strobe → `key_validn`=1, `key_code`=0, `col_n`=1110 immediately. After release with the key still held → a fresh debounce and one new strobe.
